// File: rtl/fir_filter_mac_if.sv
// Sample stream, result stream and coefficient write port of fir_filter_mac.
// master = upstream/downstream side, slave = the filter itself.
interface fir_filter_mac_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8
);
  localparam int AW = $clog2(N);

  logic signed [DATA_WIDTH-1:0] x_in;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] y_out;
  logic                         out_valid;
  logic                         out_ready;
  logic                         coef_we;
  logic [AW-1:0]                coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic                         busy;

  modport master (
    output x_in, in_valid, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, y_out, out_valid, busy
  );

  modport slave (
    input  x_in, in_valid, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, y_out, out_valid, busy
  );
endinterface

// File: rtl/fir_filter_mac.sv
// N-tap signed FIR using one time-multiplexed multiply-accumulate.
// Runtime-loadable coefficients, valid/ready on both sides, full-precision
// accumulator, round-half-up right shift and saturation on the output.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted
// MAC   | one tap product per cycle, cnt = 0..N-1
// OUT   | y_out/out_valid held until downstream handshake
module fir_filter_mac #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_SHIFT  = 0
) (
  input logic            clk,
  input logic            reset_n,
  fir_filter_mac_if.slave io
);
  localparam int AW    = $clog2(N);
  localparam int PW    = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + $clog2(N);
  // one extra bit so the rounding constant can never wrap the accumulator
  localparam int RW    = ACC_W + 1;

  localparam logic [AW-1:0]        CNT_LAST = AW'(N - 1);
  localparam logic signed [RW-1:0] RND      = (RW'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [RW-1:0] YMAX     = RW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] YMIN     = RW'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nxt;

  logic [AW-1:0]                cnt;
  logic signed [DATA_WIDTH-1:0] tap  [N];
  logic signed [COEF_WIDTH-1:0] coef [N];
  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      acc_sum;
  logic signed [PW-1:0]         prod;
  logic signed [RW-1:0]         rnd_in;
  logic signed [RW-1:0]         rnd_sh;
  logic signed [DATA_WIDTH-1:0] y_sat;
  logic signed [DATA_WIDTH-1:0] y_q;
  logic                         in_ready_q;
  logic                         out_valid_q;
  logic                         accept;
  logic                         mac_last;

  assign accept   = (state == IDLE) && io.in_valid && in_ready_q;
  assign mac_last = (state == MAC) && (cnt == CNT_LAST);
  assign prod     = tap[cnt] * coef[cnt];
  assign acc_sum  = acc + ACC_W'(prod);

  // Round-half-up, arithmetic shift and clamp of the final accumulator value.
  always_comb begin
    rnd_in = RW'(acc_sum) + RND;
    rnd_sh = rnd_in >>> OUT_SHIFT;
    y_sat  = rnd_sh[DATA_WIDTH-1:0];
    if (rnd_sh > YMAX)
      y_sat = YMAX[DATA_WIDTH-1:0];
    else if (rnd_sh < YMIN)
      y_sat = YMIN[DATA_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (cnt == CNT_LAST) state_nxt = OUT;
      OUT:     if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Delay line, coefficients, accumulator and registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        tap[k]  <= '0;
        coef[k] <= COEF_WIDTH'(1);
      end
      acc         <= '0;
      cnt         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      in_ready_q <= (state_nxt == IDLE);

      // writes while busy are dropped; a write in the accept cycle is seen by that sample
      if ((state == IDLE) && io.coef_we && (int'(io.coef_addr) < N))
        coef[io.coef_addr] <= io.coef_data;

      if (accept) begin
        for (int k = N - 1; k > 0; k--)
          tap[k] <= tap[k-1];
        tap[0] <= io.x_in;
        acc    <= '0;
        cnt    <= '0;
      end

      if (state == MAC) begin
        acc <= acc_sum;
        cnt <= mac_last ? '0 : cnt + AW'(1);
      end

      if (mac_last) begin
        y_q         <= y_sat;
        out_valid_q <= 1'b1;
      end else if ((state == OUT) && io.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.y_out     = y_q;
  assign io.out_valid = out_valid_q;
  assign io.busy      = (state != IDLE);
endmodule

// File: tb/tb_fir_filter_mac.sv
// Bench for fir_filter_mac: dut0 has OUT_SHIFT=0, dut1 has OUT_SHIFT=2.
module tb_fir_filter_mac;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int LAT = N + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic signed [DW-1:0] exp_q[$];

  fir_filter_mac_if #(.N(N), .DATA_WIDTH(DW), .COEF_WIDTH(CW)) bus0 ();
  fir_filter_mac_if #(.N(N), .DATA_WIDTH(DW), .COEF_WIDTH(CW)) bus1 ();

  fir_filter_mac #(.N(N), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .OUT_SHIFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .io(bus0));
  fir_filter_mac #(.N(N), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .OUT_SHIFT(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .io(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle_inputs();
    bus0.in_valid = 1'b0; bus0.x_in = '0; bus0.out_ready = 1'b1;
    bus0.coef_we = 1'b0; bus0.coef_addr = '0; bus0.coef_data = '0;
    bus1.in_valid = 1'b0; bus1.x_in = '0; bus1.out_ready = 1'b1;
    bus1.coef_we = 1'b0; bus1.coef_addr = '0; bus1.coef_data = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_coef(input int a, input int d);
    bus0.coef_we = 1'b1; bus0.coef_addr = 2'(a); bus0.coef_data = CW'(d);
    @(negedge clk);
    bus0.coef_we = 1'b0;
  endtask

  // Offers x on DUT w until accepted; a = cycle of acceptance (huge on timeout).
  task automatic put(input int w, input int x, output int a);
    int n = 0;
    a = 1000000;
    if (w == 0) begin bus0.x_in = DW'(x); bus0.in_valid = 1'b1; end
    else        begin bus1.x_in = DW'(x); bus1.in_valid = 1'b1; end
    while (n < 40) begin
      if ((w == 0) ? bus0.in_ready : bus1.in_ready) begin a = cyc; break; end
      @(negedge clk); n++;
    end
    @(negedge clk);
    bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
  endtask

  // Waits for out_valid on DUT w; c = cycle it is first seen (very negative on timeout).
  task automatic wait_ov(input int w, output int c);
    int n = 0;
    c = -1000000;
    while (n < 40) begin
      if ((w == 0) ? bus0.out_valid : bus1.out_valid) begin c = cyc; break; end
      @(negedge clk); n++;
    end
  endtask

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus0.in_ready); end
    n_tests++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus0.out_valid); end
    n_tests++; if (bus0.y_out !== 8'sd0) begin n_fail++; $display("FAIL reset_y_out: got %0d want 0", bus0.y_out); end
    n_tests++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
    n_tests++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid1: got %b want 0", bus1.out_valid); end
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", bus0.in_ready); end
    n_tests++; if (bus1.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready1: got %b want 1", bus1.in_ready); end
    n_tests++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL release_busy: got %b want 0", bus0.busy); end
  endtask

  task automatic test_impulse();
    int cf[4] = '{1, 2, 2, 1};
    int xs[4] = '{1, 0, 0, 0};
    int ys[4] = '{1, 2, 2, 1};
    int a, c;
    logic signed [DW-1:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) write_coef(i, cf[i]);
    for (int i = 0; i < 4; i++) begin
      put(0, xs[i], a); exp_q.push_back(DW'(ys[i]));
      wait_ov(0, c);
      e = exp_q.pop_front();
      n_tests++; if (bus0.y_out !== e) begin n_fail++; $display("FAIL impulse_y[%0d]: got %0d want %0d", i, bus0.y_out, e); end
      n_tests++; if (c - a !== LAT) begin n_fail++; $display("FAIL impulse_latency[%0d]: got %0d want %0d", i, c - a, LAT); end
      @(negedge clk);
    end
  endtask

  task automatic test_default_coefs();
    int xs[4] = '{10, 20, 30, 40};
    int ys[4] = '{10, 30, 60, 100};
    int a, c;
    logic signed [DW-1:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put(0, xs[i], a); exp_q.push_back(DW'(ys[i]));
      wait_ov(0, c);
      e = exp_q.pop_front();
      n_tests++; if (bus0.y_out !== e) begin n_fail++; $display("FAIL default_y[%0d]: got %0d want %0d", i, bus0.y_out, e); end
      n_tests++; if (c - a !== LAT) begin n_fail++; $display("FAIL default_latency[%0d]: got %0d want %0d", i, c - a, LAT); end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    int xs[8] = '{127, 127, 127, 127, -128, -128, -128, -128};
    int ys[8] = '{127, 127, 127, 127, 127, -128, -128, -128};
    int a, c;
    logic signed [DW-1:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) write_coef(i, 127);
    for (int i = 0; i < 8; i++) begin
      put(0, xs[i], a); exp_q.push_back(DW'(ys[i]));
      wait_ov(0, c);
      e = exp_q.pop_front();
      n_tests++; if (bus0.y_out !== e) begin n_fail++; $display("FAIL sat_y[%0d]: got %0d want %0d", i, bus0.y_out, e); end
      n_tests++; if (c - a !== LAT) begin n_fail++; $display("FAIL sat_latency[%0d]: got %0d want %0d", i, c - a, LAT); end
      @(negedge clk);
    end
  endtask

  task automatic test_rounding();
    int xs[7] = '{1, 1, 1, 1, -3, -4, 0};
    int ys[7] = '{0, 1, 1, 1, -1, -2, -2};
    int a, c;
    logic signed [DW-1:0] e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i == 4) do_reset();
      put(1, xs[i], a); exp_q.push_back(DW'(ys[i]));
      wait_ov(1, c);
      e = exp_q.pop_front();
      n_tests++; if (bus1.y_out !== e) begin n_fail++; $display("FAIL round_y[%0d]: got %0d want %0d", i, bus1.y_out, e); end
      n_tests++; if (c - a !== LAT) begin n_fail++; $display("FAIL round_latency[%0d]: got %0d want %0d", i, c - a, LAT); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int a, c;
    bit bad_v, bad_y, bad_r;
    do_reset();
    bus0.out_ready = 1'b0;
    put(0, 42, a);
    wait_ov(0, c);
    n_tests++; if (c - a !== LAT) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", c - a, LAT); end
    bad_v = 0; bad_y = 0; bad_r = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus0.out_valid !== 1'b1) bad_v = 1;
      if (bus0.y_out !== 8'sd42) bad_y = 1;
      if (bus0.in_ready !== 1'b0) bad_r = 1;
      @(negedge clk);
    end
    n_tests++; if (bad_v !== 1'b0) begin n_fail++; $display("FAIL bp_hold_valid: got unstable want held 1"); end
    n_tests++; if (bad_y !== 1'b0) begin n_fail++; $display("FAIL bp_hold_y: got unstable want held 42"); end
    n_tests++; if (bad_r !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got 1 want 0 while stalled"); end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", bus0.out_valid); end
    n_tests++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", bus0.in_ready); end
    put(0, 8, a); exp_q.push_back(8'sd50);
    wait_ov(0, c);
    n_tests++; if (bus0.y_out !== exp_q.pop_front()) begin n_fail++; $display("FAIL bp_next_y: got %0d want 50", bus0.y_out); end
    @(negedge clk);
  endtask

  task automatic test_busy_write();
    int a, c;
    logic signed [DW-1:0] e;
    do_reset();
    put(0, 5, a); exp_q.push_back(8'sd5);
    n_tests++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_mac: got %b want 1", bus0.busy); end
    write_coef(0, 50);
    wait_ov(0, c);
    e = exp_q.pop_front();
    n_tests++; if (bus0.y_out !== e) begin n_fail++; $display("FAIL busywr_y0: got %0d want %0d", bus0.y_out, e); end
    @(negedge clk);
    // coef[1] <= 3 in the same cycle the sample 7 is accepted; coef[0] must still be 1
    bus0.coef_we = 1'b1; bus0.coef_addr = 2'd1; bus0.coef_data = 8'sd3;
    put(0, 7, a); exp_q.push_back(8'sd22);
    bus0.coef_we = 1'b0;
    wait_ov(0, c);
    e = exp_q.pop_front();
    n_tests++; if (bus0.y_out !== e) begin n_fail++; $display("FAIL busywr_y1: got %0d want %0d", bus0.y_out, e); end
    @(negedge clk);
    put(0, 0, a); exp_q.push_back(8'sd26);
    wait_ov(0, c);
    e = exp_q.pop_front();
    n_tests++; if (bus0.y_out !== e) begin n_fail++; $display("FAIL busywr_y2: got %0d want %0d", bus0.y_out, e); end
    @(negedge clk);
  endtask

  task automatic test_midop_reset();
    int xs[4] = '{4, 3, 2, 1};
    int ys[4] = '{4, 7, 9, 10};
    int a, c;
    bit saw_ov;
    logic signed [DW-1:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) write_coef(i, 2);
    put(0, 9, a);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_tests++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", bus0.out_valid); end
    n_tests++; if (bus0.y_out !== 8'sd0) begin n_fail++; $display("FAIL midrst_y: got %0d want 0", bus0.y_out); end
    n_tests++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus0.busy); end
    n_tests++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 0", bus0.in_ready); end
    saw_ov = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (bus0.out_valid !== 1'b0) saw_ov = 1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus0.out_valid !== 1'b0) saw_ov = 1;
    end
    n_tests++; if (saw_ov !== 1'b0) begin n_fail++; $display("FAIL midrst_no_output: got out_valid 1 want 0"); end
    for (int i = 0; i < 4; i++) begin
      put(0, xs[i], a); exp_q.push_back(DW'(ys[i]));
      wait_ov(0, c);
      e = exp_q.pop_front();
      n_tests++; if (bus0.y_out !== e) begin n_fail++; $display("FAIL midrst_y[%0d]: got %0d want %0d", i, bus0.y_out, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int mt[N];
    int mc[N];
    int a, a_prev, c, acc;
    logic signed [DW-1:0] e;
    do_reset();
    for (int k = 0; k < N; k++) begin
      mt[k] = 0;
      mc[k] = $urandom_range(255) - 128;
      write_coef(k, mc[k]);
    end
    a_prev = 0;
    for (int i = 0; i < 12; i++) begin
      int x;
      x = $urandom_range(255) - 128;
      put(0, x, a);
      for (int k = N - 1; k > 0; k--) mt[k] = mt[k-1];
      mt[0] = x;
      acc = 0;
      for (int k = 0; k < N; k++) acc += mt[k] * mc[k];
      exp_q.push_back(DW'(sat(acc)));
      if (i > 0) begin
        n_tests++; if (a - a_prev !== N + 2) begin n_fail++; $display("FAIL b2b_period[%0d]: got %0d want %0d", i, a - a_prev, N + 2); end
      end
      a_prev = a;
      wait_ov(0, c);
      e = exp_q.pop_front();
      n_tests++; if (bus0.y_out !== e) begin n_fail++; $display("FAIL b2b_y[%0d]: got %0d want %0d", i, bus0.y_out, e); end
      n_tests++; if (c - a !== LAT) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, c - a, LAT); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_default_coefs();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_busy_write();
    test_midop_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
